// File: rtl/dog_pkg.sv
// dog_pkg
// Shared definitions for the toy dog behaviour controller.
//   - MOOD_* : 3-bit mood codes that go to the 7-segment decoder as {A,B,C}.
//   - state_t: FSM state encoding. Each state's value equals its mood code, so the
//              state register can drive the display pins directly.
//   - max_int: helper used when sizing the dwell timer.
package dog_pkg;

  localparam logic [2:0] MOOD_SLEEP  = 3'b000;
  localparam logic [2:0] MOOD_IDLE   = 3'b001;
  localparam logic [2:0] MOOD_HAPPY  = 3'b010;
  localparam logic [2:0] MOOD_HUNGRY = 3'b011;
  localparam logic [2:0] MOOD_EATING = 3'b100;
  localparam logic [2:0] MOOD_BARK   = 3'b101;

  typedef enum logic [2:0] {
    ST_SLEEP  = MOOD_SLEEP,
    ST_IDLE   = MOOD_IDLE,
    ST_HAPPY  = MOOD_HAPPY,
    ST_HUNGRY = MOOD_HUNGRY,
    ST_EATING = MOOD_EATING,
    ST_BARK   = MOOD_BARK
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Brings one asynchronous level into the clk domain through two flops, then
// emits a single-cycle pulse when the synchronized level goes from 0 to 1.
// A level that stays high therefore produces exactly one pulse.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset, clears every flop
//   din   in  asynchronous input level
//   rise  out one-cycle pulse on a synchronized rising edge
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync_meta;
  logic sync_q;
  logic sync_d;

  // Two synchronizer stages followed by one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
      sync_d    <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_d;

endmodule

// File: rtl/dog_behavior_fsm.sv
// dog_behavior_fsm
// Behaviour controller for the toy dog. Samples the pet and feed buttons (and the
// noise sensor when barking is built in), and runs a timed mood state machine.
// The registered mood code drives the 7-segment decoder stage downstream.
// Optional feature macro: DOG_BARK_EN (noise input, BARK state and its dwell).
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-high reset (state IDLE, code 001)
//   btn_pet  in  debounced pet button level (asynchronous)
//   btn_feed in  debounced feed button level (asynchronous)
//   noise    in  sound sensor level (asynchronous), used only with DOG_BARK_EN
//   A,B,C    out mood code MSB..LSB, straight from the state register
module dog_behavior_fsm #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int IDLE_TICKS   = 10,
  parameter int HUNGER_TICKS = 20,
  parameter int EAT_TICKS    = 3,
  parameter int HAPPY_TICKS  = 5,
  parameter int BARK_TICKS   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pet,
  input  logic btn_feed,
  input  logic noise,
  output logic A,
  output logic B,
  output logic C
);
  import dog_pkg::*;

  localparam int MAX_TICKS = max_int(max_int(max_int(IDLE_TICKS, HUNGER_TICKS),
                                             max_int(EAT_TICKS, HAPPY_TICKS)),
                                     BARK_TICKS);
  localparam int TIMER_W = $clog2(MAX_TICKS) + 1;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t              state;
  state_t              state_next;
  logic                load;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  dwell_load;
  logic [PRESC_W-1:0]  presc;
  logic                tick;
  logic                timeout;
  logic                feed_ev;
  logic                pet_ev;

  sync_edge u_feed_sync (
    .clk   (clk),
    .reset (reset),
    .din   (btn_feed),
    .rise  (feed_ev)
  );

  sync_edge u_pet_sync (
    .clk   (clk),
    .reset (reset),
    .din   (btn_pet),
    .rise  (pet_ev)
  );

`ifdef DOG_BARK_EN
  logic noise_ev;

  sync_edge u_noise_sync (
    .clk   (clk),
    .reset (reset),
    .din   (noise),
    .rise  (noise_ev)
  );
`else
  logic unused_noise;
  assign unused_noise = noise;
`endif

  assign tick    = (presc == PRESC_W'(TICK_DIV - 1));
  assign timeout = tick && (timer == TIMER_W'(1));

  // Dwell length for the state being entered. HUNGRY has no timeout, so it loads
  // zero and the timer then sits there without decrementing.
  always_comb begin
    dwell_load = '0;
    case (state_next)
      ST_IDLE:   dwell_load = TIMER_W'(IDLE_TICKS);
      ST_SLEEP:  dwell_load = TIMER_W'(HUNGER_TICKS);
      ST_EATING: dwell_load = TIMER_W'(EAT_TICKS);
      ST_HAPPY:  dwell_load = TIMER_W'(HAPPY_TICKS);
      ST_BARK:   dwell_load = TIMER_W'(BARK_TICKS);
      default:   dwell_load = '0;
    endcase
  end

  // Next-state logic. Events are one-cycle pulses and are checked in priority
  // order feed > pet > noise > timeout; an event a state ignores is simply lost.
  // 'load' marks every state entry, including HAPPY re-entering itself on a pet,
  // so the dwell timer and prescaler restart from a clean boundary.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (feed_ev) begin
          state_next = ST_EATING;
          load       = 1'b1;
        end else if (pet_ev) begin
          state_next = ST_HAPPY;
          load       = 1'b1;
`ifdef DOG_BARK_EN
        end else if (noise_ev) begin
          state_next = ST_BARK;
          load       = 1'b1;
`endif
        end else if (timeout) begin
          state_next = ST_SLEEP;
          load       = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (feed_ev) begin
          state_next = ST_EATING;
          load       = 1'b1;
        end else if (pet_ev) begin
          state_next = ST_IDLE;
          load       = 1'b1;
`ifdef DOG_BARK_EN
        end else if (noise_ev) begin
          state_next = ST_BARK;
          load       = 1'b1;
`endif
        end else if (timeout) begin
          state_next = ST_HUNGRY;
          load       = 1'b1;
        end
      end
      ST_HUNGRY: begin
        if (feed_ev) begin
          state_next = ST_EATING;
          load       = 1'b1;
        end
      end
      ST_EATING: begin
        if (timeout) begin
          state_next = ST_HAPPY;
          load       = 1'b1;
        end
      end
      ST_HAPPY: begin
        if (feed_ev) begin
          state_next = ST_EATING;
          load       = 1'b1;
        end else if (pet_ev) begin
          state_next = ST_HAPPY;
          load       = 1'b1;
        end else if (timeout) begin
          state_next = ST_IDLE;
          load       = 1'b1;
        end
      end
`ifdef DOG_BARK_EN
      ST_BARK: begin
        if (timeout) begin
          state_next = ST_IDLE;
          load       = 1'b1;
        end
      end
`endif
      default: begin
        // Unused encodings (and BARK when it is not built in) recover to IDLE.
        state_next = ST_IDLE;
        load       = 1'b1;
      end
    endcase
  end

  // State register plus dwell timer and tick prescaler. On each state entry the
  // prescaler restarts at 0 so a dwell of N ticks lasts exactly N*TICK_DIV cycles.
  // The timer saturates at zero rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      presc <= '0;
      timer <= TIMER_W'(IDLE_TICKS);
    end else if (load) begin
      state <= state_next;
      presc <= '0;
      timer <= dwell_load;
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick && (timer != '0)) begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

  assign {A, B, C} = state;

endmodule

// File: tb/tb_dog_behavior_fsm.sv
// tb_dog_behavior_fsm
// Directed bench for dog_behavior_fsm with TICK_DIV=4 and short dwell times.
// The stimulus process queues the mood code it expects next together with the
// cycle count at which it must appear; a monitor watches {A,B,C} on every falling
// clock edge and pops one expectation per code change.
module tb_dog_behavior_fsm;

  localparam int TICK_DIV     = 4;
  localparam int IDLE_TICKS   = 5;
  localparam int HUNGER_TICKS = 6;
  localparam int EAT_TICKS    = 3;
  localparam int HAPPY_TICKS  = 4;
  localparam int BARK_TICKS   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pet = 1'b0;
  logic       btn_feed = 1'b0;
  logic       noise = 1'b0;
  logic       A;
  logic       B;
  logic       C;
  logic [2:0] mood;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] code;
    int         at;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  assign mood = {A, B, C};

  dog_behavior_fsm #(
    .TICK_DIV     (TICK_DIV),
    .IDLE_TICKS   (IDLE_TICKS),
    .HUNGER_TICKS (HUNGER_TICKS),
    .EAT_TICKS    (EAT_TICKS),
    .HAPPY_TICKS  (HAPPY_TICKS),
    .BARK_TICKS   (BARK_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_pet  (btn_pet),
    .btn_feed (btn_feed),
    .noise    (noise),
    .A        (A),
    .B        (B),
    .C        (C)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Count rising edges so expectations can name the edge that causes a change.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic feed, input logic pet, input logic nz);
    btn_feed = feed;
    btn_pet  = pet;
    noise    = nz;
  endtask

  // Advance to a falling edge whose cycle count has reached the target.
  task automatic go_to(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Raise the given inputs for one cycle, starting at the current falling edge.
  task automatic pulse(input logic feed, input logic pet, input logic nz);
    applyStimulus(feed, pet, nz);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_code(input logic [2:0] code, input int at, input string name);
    exp_t e;
    e.code = code;
    e.at   = at;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of the mood code must match the oldest queued
  // expectation in both value and cycle; a change with nothing queued is an error.
  initial begin : monitor
    logic [2:0] last_code;
    exp_t       e;
    last_code = 3'b001;
    forever begin
      @(negedge clk);
      if (mood !== last_code) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_change actual=%b expected=%b (cyc %0d)",
                   mood, last_code, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput({e.name, "_code"}, int'(mood), int'(e.code));
          checkOutput({e.name, "_cycle"}, cyc, e.at);
        end
        last_code = mood;
      end
    end
  end

  // Directed scenarios; expected cycles are hand-computed from TICK_DIV=4:
  // input edges take 3 edges to reach the display, and dwells are
  // IDLE 20, SLEEP 24, EATING 12, HAPPY 16, BARK 8 cycles.
  initial begin : stimulus
    int t;
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    go_to(2);
    checkOutput("reset_code", int'(mood), 1);

    // Idle timeout, then sleep into hunger, then hold there.
    reset = 1'b0;
    t = cyc;
    expect_code(3'b000, t + 20, "idle_timeout");
    expect_code(3'b011, t + 44, "hunger_timeout");
    go_to(t + 144);

    // Feed from HUNGRY.
    t = cyc;
    expect_code(3'b100, t + 3,  "feed_hungry");
    expect_code(3'b010, t + 15, "eat_done");
    expect_code(3'b001, t + 31, "happy_done");
    pulse(1'b1, 1'b0, 1'b0);

    // Held pet in IDLE: one transition only.
    go_to(t + 33);
    t = cyc;
    expect_code(3'b010, t + 3,  "held_pet");
    expect_code(3'b001, t + 19, "held_pet_timeout");
    applyStimulus(1'b0, 1'b1, 1'b0);
    go_to(t + 30);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Simultaneous feed, pet and noise in IDLE: feed wins.
    go_to(t + 32);
    t = cyc;
    expect_code(3'b100, t + 3,  "simultaneous");
    expect_code(3'b010, t + 15, "simul_eat_done");
    expect_code(3'b001, t + 31, "simul_happy_done");
    expect_code(3'b000, t + 51, "idle_to_sleep");
    pulse(1'b1, 1'b1, 1'b1);

    // Noise while asleep.
    go_to(t + 53);
    t = cyc;
`ifdef DOG_BARK_EN
    expect_code(3'b101, t + 3,  "noise_bark");
    expect_code(3'b001, t + 11, "bark_done");
    pulse(1'b0, 1'b0, 1'b1);
    go_to(t + 13);
`else
    pulse(1'b0, 1'b0, 1'b1);
    go_to(t + 5);
`endif

    // Enter EATING, then assert reset between clock edges.
    t = cyc;
    expect_code(3'b100, t + 3, "feed_before_reset");
    pulse(1'b1, 1'b0, 1'b0);
    go_to(t + 6);
    #2;
    expect_code(3'b001, t + 7, "async_reset");
    reset = 1'b1;
    #1;
    checkOutput("async_reset_immediate", int'(mood), 1);

    // Release reset: idle timeout restarts from the first edge after release.
    go_to(t + 9);
    reset = 1'b0;
    t = cyc;
    expect_code(3'b000, t + 20, "post_reset_timeout");
    go_to(t + 24);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
